// File: rtl/mem_pkg.sv
// Shared widths and types for the MEM-stage data memory.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/data_mem.sv
// 256 x 8 data memory: synchronous write, combinational gated read, async active-low clear.
// Optional build macro MEM_WR_FWD_EN forwards WriteData to ReadData on a same-cycle read/write.
module data_mem
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData
);

  data_t mem_q [DEPTH];

  // Clearing the whole array on reset keeps ReadData X-free from the first reset onward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWrite) begin
      mem_q[Address] <= WriteData;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      ReadData = mem_q[Address];
    end
`ifdef MEM_WR_FWD_EN
    if (MemRead && MemWrite) begin
      ReadData = WriteData;
    end
`else
`endif
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed and random checks of data_mem against a 256-entry reference array.
`timescale 1ns/1ps
module tb_data_mem;

  logic       clk;
  logic       rst;
  logic       MemWrite;
  logic       MemRead;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic [7:0] ReadData;

  logic [7:0] model [256];
  int         checks;
  int         failures;

  data_mem dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    Address   = a;
    WriteData = d;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    model[a]  = d;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Address  = a;
    #1;
    check(tag, ReadData, exp);
  endtask

  initial begin
    logic       we, re;
    logic [7:0] a, d, exp;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Address   = 8'h00;
    WriteData = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    // Reset: held low for 100ns, reads return zero
    #2 rst = 1'b0;
    #100;
    read_check("rst_rd_00", 8'h00, 8'h00);
    read_check("rst_rd_ff", 8'hFF, 8'h00);
    @(negedge clk); #2;
    rst = 1'b1;

    // Write then read, gated read
    write_word(8'h10, 8'hA5);
    read_check("wr_rd_10", 8'h10, 8'hA5);
    MemRead = 1'b0; #1;
    check("rd_gated", ReadData, 8'h00);

    // Address extremes
    write_word(8'hFF, 8'h3C);
    write_word(8'h00, 8'hC3);
    read_check("edge_ff", 8'hFF, 8'h3C);
    read_check("edge_00", 8'h00, 8'hC3);
    read_check("other_01", 8'h01, 8'h00);
    read_check("other_fe", 8'hFE, 8'h00);
    read_check("other_80", 8'h80, 8'h00);

    // Same-cycle read and write
    write_word(8'h20, 8'h11);
    @(negedge clk); #1;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Address   = 8'h20;
    WriteData = 8'h22;
    #1;
`ifdef MEM_WR_FWD_EN
    check("rw_before", ReadData, 8'h22);
`else
    check("rw_before", ReadData, 8'h11);
`endif
    @(posedge clk); #1;
    check("rw_after", ReadData, 8'h22);
    MemWrite  = 1'b0;
    model[8'h20] = 8'h22;
    #1;
    check("rw_stored", ReadData, 8'h22);

    // Async reset mid-cycle, write attempted during reset
    @(negedge clk); #2;
    read_check("pre_arst", 8'h10, 8'hA5);
    rst = 1'b0;
    #1;
    check("arst_now", ReadData, 8'h00);
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    WriteData = 8'h77;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    read_check("rst_wr_ign", 8'h10, 8'h00);
    read_check("rst_clr_20", 8'h20, 8'h00);
    read_check("rst_clr_ff", 8'hFF, 8'h00);
    @(negedge clk); #2;
    rst = 1'b1;

    // Random traffic against the reference model
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk); #1;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      MemWrite  = we;
      MemRead   = re;
      Address   = a;
      WriteData = d;
      #1;
      exp = re ? model[a] : 8'h00;
`ifdef MEM_WR_FWD_EN
      if (re && we) exp = d;
`endif
      check("rand_rd", ReadData, exp);
      @(posedge clk); #1;
      if (we) model[a] = d;
    end
    MemWrite = 1'b0;

    // Final sweep of the whole array
    for (int i = 0; i < 256; i++) begin
      read_check("sweep", 8'(i), model[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
